// File: rtl/i2s_frame_sequencer.sv
// I2S master frame sequencer: word-select, frame-start and word-last strobes in the sck_i domain.
// Optional build macro I2S_WS_EARLY_EN gives ws_o a one-bit lead (Philips timing).
module i2s_frame_sequencer #(
   parameter bit SYNC_STOP = 1'b1
) (
   input  logic       sck_i,
   input  logic       rstn_i,
   input  logic       cfg_en_i,
   input  logic [4:0] cfg_bits_word_i,
   input  logic [2:0] cfg_words_i,
   output logic       ws_o,
   output logic       frame_start_o,
   output logic       word_last_o,
   output logic       busy_o
);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t     state_q, state_d;
   logic [4:0] nb_q, nb_d, bit_q, bit_d;
   logic [2:0] nw_q, nw_d, word_q, word_d;
   logic       ch_q, ch_d;
   logic       busy, word_end, slot_end, wrap;

   assign busy     = (state_q != IDLE);
   assign word_end = busy && (bit_q == nb_q);
   assign slot_end = word_end && (word_q == nw_q);
   assign wrap     = slot_end && ch_q;

   always_comb begin
      state_d = state_q;
      nb_d    = nb_q;
      nw_d    = nw_q;
      bit_d   = bit_q;
      word_d  = word_q;
      ch_d    = ch_q;

      if (busy) begin
         bit_d = word_end ? 5'd0 : bit_q + 5'd1;
         if (word_end) word_d = slot_end ? 3'd0 : word_q + 3'd1;
         if (slot_end) ch_d = ~ch_q;
         // New configuration only takes effect on a frame boundary
         if (wrap) begin
            nb_d = cfg_bits_word_i;
            nw_d = cfg_words_i;
         end
      end

      case (state_q)
         IDLE: if (cfg_en_i) begin
            state_d = RUN;
            nb_d    = cfg_bits_word_i;
            nw_d    = cfg_words_i;
         end
         RUN:  if (!cfg_en_i) state_d = STOP;
         STOP: begin
            // Re-enable wins over a pending stop so framing never gaps
            if (cfg_en_i) state_d = RUN;
            else if (SYNC_STOP ? wrap : word_end) begin
               state_d = IDLE;
               bit_d   = 5'd0;
               word_d  = 3'd0;
               ch_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sck_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= IDLE;
         nb_q    <= 5'd0;
         nw_q    <= 3'd0;
         bit_q   <= 5'd0;
         word_q  <= 3'd0;
         ch_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         nb_q    <= nb_d;
         nw_q    <= nw_d;
         bit_q   <= bit_d;
         word_q  <= word_d;
         ch_q    <= ch_d;
      end
   end

`ifdef I2S_WS_EARLY_EN
   logic ws_q, ws_d;

   // Look one cycle ahead: if the next cycle closes a slot, ws already shows the following channel
   always_comb begin
      ws_d = 1'b0;
      if (state_d != IDLE) begin
         ws_d = ch_d;
         if (bit_d == nb_d && word_d == nw_d) ws_d = ~ch_d;
         if (state_d == STOP && !SYNC_STOP && bit_d == nb_d) ws_d = 1'b0;
      end
   end

   always_ff @(posedge sck_i or negedge rstn_i) begin
      if (!rstn_i) ws_q <= 1'b0;
      else         ws_q <= ws_d;
   end

   assign ws_o = ws_q;
`else
   assign ws_o = ch_q;
`endif

   assign busy_o        = busy;
   assign word_last_o   = word_end;
   assign frame_start_o = busy && (bit_q == 5'd0) && (word_q == 3'd0) && !ch_q;

endmodule

// File: tb/tb_i2s_frame_sequencer.sv
// Self-checking bench for i2s_frame_sequencer: directed vector table, corner sequences, random vs frame-position model.
module tb_i2s_frame_sequencer;

   logic       sck_i = 1'b0;
   logic       rstn_i = 1'b0;
   logic       cfg_en_i = 1'b0;
   logic [4:0] cfg_bits_word_i = 5'd0;
   logic [2:0] cfg_words_i = 3'd0;
   logic       ws_o, frame_start_o, word_last_o, busy_o;

   int tests = 0;
   int fails = 0;

   i2s_frame_sequencer dut (
      .sck_i(sck_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i),
      .cfg_bits_word_i(cfg_bits_word_i), .cfg_words_i(cfg_words_i),
      .ws_o(ws_o), .frame_start_o(frame_start_o),
      .word_last_o(word_last_o), .busy_o(busy_o)
   );

   always #5 sck_i = ~sck_i;

   // Reference model: position inside the frame as a plain integer
   int m_st = 0;   // 0 idle, 1 run, 2 stop
   int m_pos = 0;
   int m_nb = 0;
   int m_nw = 0;

   task automatic model_reset();
      m_st = 0; m_pos = 0; m_nb = 0; m_nw = 0;
   endtask

   task automatic model_step(input logic en, input int cb, input int cw);
      int  len;
      bit  wr;
      if (m_st == 0) begin
         if (en) begin m_st = 1; m_pos = 0; m_nb = cb; m_nw = cw; end
      end else begin
         len = 2 * (m_nb + 1) * (m_nw + 1);
         wr  = (m_pos == len - 1);
         m_pos = wr ? 0 : m_pos + 1;
         if (wr) begin m_nb = cb; m_nw = cw; end
         if (m_st == 1) begin
            if (!en) m_st = 2;
         end else begin
            if (en) m_st = 1;
            else if (wr) begin m_st = 0; m_pos = 0; end
         end
      end
   endtask

   task automatic tick();
      @(posedge sck_i);
      if (!rstn_i) model_reset();
      else model_step(cfg_en_i, int'(cfg_bits_word_i), int'(cfg_words_i));
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string name, input logic b, input logic f, input logic w, input logic s);
      tests++;
      if (busy_o !== b || frame_start_o !== f || word_last_o !== w || ws_o !== s) begin
         fails++;
         $display("FAIL %s: got busy=%b fs=%b wl=%b ws=%b, expected busy=%b fs=%b wl=%b ws=%b",
                  name, busy_o, frame_start_o, word_last_o, ws_o, b, f, w, s);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   task automatic do_reset();
      rstn_i = 1'b0;
      model_reset();
      cfg_en_i = 1'b0;
      ticks(2);
      rstn_i = 1'b1;
      tick();
   endtask

   // Ticks until frame_start_o is seen; bounded so a stuck DUT still reports
   task automatic ticks_to_fs(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!frame_start_o && n < 600);
   endtask

   typedef struct packed {
      logic       en;
      logic [4:0] nb;
      logic [2:0] nw;
      int         n;
      logic       busy, fs, wl, ws;
   } vec_t;

   vec_t tbl [16];

   initial begin
      int n, bad;
      bit mb, mf, mw, ms;
      int slot;

      tbl[0]  = '{1'b0, 5'd15, 3'd0,  5, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 5'd15, 3'd0,  1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 5'd15, 3'd0, 15, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 5'd15, 3'd0,  1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 5'd15, 3'd0, 15, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[5]  = '{1'b1, 5'd15, 3'd0,  1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 5'd7,  3'd3, 10, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 5'd7,  3'd3, 21, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{1'b1, 5'd7,  3'd3,  1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 5'd7,  3'd3,  7, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 5'd7,  3'd3, 25, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 5'd7,  3'd3, 31, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[12] = '{1'b1, 5'd7,  3'd3,  1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{1'b0, 5'd7,  3'd3,  5, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 5'd7,  3'd3, 58, 1'b1, 1'b0, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 5'd7,  3'd3,  1, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset hold, then idle for 100 cycles
      rstn_i = 1'b0;
      #2;
      chk("reset_state", 1'b0, 1'b0, 1'b0, 1'b0);
      ticks(3);
      rstn_i = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (busy_o | frame_start_o | word_last_o | ws_o) bad++;
      end
      chk_int("idle_100_nonzero_cycles", bad, 0);

      // Directed table: basic framing, multi-word, reconfig at wrap, graceful stop
      for (int i = 0; i < 16; i++) begin
         cfg_en_i = tbl[i].en;
         cfg_bits_word_i = tbl[i].nb;
         cfg_words_i = tbl[i].nw;
         ticks(tbl[i].n);
         chk($sformatf("vec%0d", i), tbl[i].busy, tbl[i].fs, tbl[i].wl, tbl[i].ws);
      end

      // Mid-frame reconfiguration 15 -> 23 at cycle 10
      do_reset();
      cfg_bits_word_i = 5'd15; cfg_words_i = 3'd0; cfg_en_i = 1'b1;
      tick();
      ticks(10);
      cfg_bits_word_i = 5'd23;
      ticks_to_fs(n);
      chk_int("reconfig_rest_of_old_frame", n, 22);
      ticks_to_fs(n);
      chk_int("reconfig_new_frame_len", n, 48);

      // Enable falls in the last cycle of a frame: one more full frame
      do_reset();
      cfg_bits_word_i = 5'd15; cfg_words_i = 3'd0; cfg_en_i = 1'b1;
      tick();
      ticks(31);
      cfg_en_i = 1'b0;
      tick();
      chk("en_fall_last_next_frame", 1'b1, 1'b1, 1'b0, 1'b0);
      ticks(31);
      chk("en_fall_last_final_cycle", 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      chk("en_fall_last_idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // Re-enable during STOP: frames continue without gap
      do_reset();
      cfg_en_i = 1'b1;
      tick();
      ticks(5);
      cfg_en_i = 1'b0;
      ticks(15);
      cfg_en_i = 1'b1;
      ticks(12);
      chk("reenable_frame1", 1'b1, 1'b1, 1'b0, 1'b0);
      ticks(32);
      chk("reenable_frame2", 1'b1, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset at cycle 20 of a frame
      do_reset();
      cfg_en_i = 1'b1;
      tick();
      ticks(20);
      chk("pre_async_rst", 1'b1, 1'b0, 1'b0, 1'b1);
      #2 rstn_i = 1'b0;
      model_reset();
      #1;
      chk("async_rst_clear", 1'b0, 1'b0, 1'b0, 1'b0);
      #1 rstn_i = 1'b1;
      tick();
      chk("post_rst_start", 1'b1, 1'b1, 1'b0, 1'b0);

      // Degenerate configuration: one-bit words, one word per slot
      do_reset();
      cfg_bits_word_i = 5'd0; cfg_words_i = 3'd0; cfg_en_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("degen%0d", i), 1'b1, (i % 2 == 0), 1'b1, (i % 2 == 1));
      end

      // Random enable/config traffic against the frame-position model
      do_reset();
      cfg_en_i = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) cfg_en_i = ~cfg_en_i;
         if ($urandom_range(0, 15) == 0) begin
            cfg_bits_word_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                          : 5'($urandom_range(0, 5));
            cfg_words_i = 3'($urandom_range(0, 7));
         end
         tick();
         slot = (m_nb + 1) * (m_nw + 1);
         mb = (m_st != 0);
         mf = mb && (m_pos == 0);
         mw = mb && ((m_pos % (m_nb + 1)) == m_nb);
         ms = mb && (((m_pos / slot) % 2) == 1);
         chk($sformatf("rand%0d", i), mb, mf, mw, ms);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
